thumb_fetch_buffer: RTL and testbench

- Front end of the pipeline. Fetches aligned 32-bit words from instruction memory and splits them into a stream of 16-bit Thumb halfwords for decode and immediate generation.
- Tags the second halfword of every 32-bit Thumb instruction so decode can pair it with the stored prefix.
- Handles branch redirects by flushing buffered halfwords and discarding any stale memory response.

---
 rtl/thumb_fetch_buffer_pkg.sv | 31 +++
 rtl/thumb_fetch_buffer_halfword_fifo.sv | 53 +++++
 rtl/thumb_fetch_buffer.sv | 135 +++++++++++++
 tb/tb_thumb_fetch_buffer.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/thumb_fetch_buffer_pkg.sv
// Shared widths, Thumb-2 prefix encodings and small helpers for the fetch buffer.
package thumb_fetch_buffer_pkg;

    localparam int HALF_WORD = 16;
    localparam int WORD      = 32;

    // Top five bits of the first halfword of every 32-bit Thumb instruction.
    localparam logic [4:0] T32_PREFIX_0 = 5'b11101;
    localparam logic [4:0] T32_PREFIX_1 = 5'b11110;
    localparam logic [4:0] T32_PREFIX_2 = 5'b11111;

    typedef enum logic {
        ST_IDLE = 1'b0,   // no memory read outstanding
        ST_WAIT = 1'b1    // one memory read outstanding
    } fetch_state_e;

    // Write side of the halfword FIFO for one cycle.
    typedef struct packed {
        logic                 push1;  // push hw0 only
        logic                 push2;  // push hw0 then hw1
        logic [HALF_WORD-1:0] hw0;
        logic [HALF_WORD-1:0] hw1;
    } fifo_push_t;

    function automatic logic is_t32_prefix(input logic [HALF_WORD-1:0] hw);
        return (hw[15:11] == T32_PREFIX_0) ||
               (hw[15:11] == T32_PREFIX_1) ||
               (hw[15:11] == T32_PREFIX_2);
    endfunction

endpackage

// File: rtl/thumb_fetch_buffer_halfword_fifo.sv
// Circular halfword FIFO accepting up to two writes and one read per cycle.
module halfword_fifo
    import thumb_fetch_buffer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     flush_i,
    input  logic                     push1_i,
    input  logic                     push2_i,
    input  logic [HALF_WORD-1:0]     wdata0_i,
    input  logic [HALF_WORD-1:0]     wdata1_i,
    input  logic                     pop_i,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [HALF_WORD-1:0]     head_o
);

    localparam int AW = $clog2(DEPTH);

    logic [HALF_WORD-1:0] mem_q [DEPTH];
    logic [AW-1:0]        wr_ptr_q;
    logic [AW-1:0]        rd_ptr_q;
    logic [AW:0]          count_q;
    logic [AW-1:0]        wr_ptr_nx;
    logic [AW:0]          n_push;

    assign wr_ptr_nx = wr_ptr_q + AW'(1);
    assign n_push    = push2_i ? (AW+1)'(2) : (push1_i ? (AW+1)'(1) : '0);
    assign count_o   = count_q;
    assign head_o    = mem_q[rd_ptr_q];

    // Storage and pointers; storage is cleared on reset so the head is never X.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push1_i || push2_i) mem_q[wr_ptr_q]  <= wdata0_i;
            if (push2_i)            mem_q[wr_ptr_nx] <= wdata1_i;
            wr_ptr_q <= wr_ptr_q + n_push[AW-1:0];
            if (pop_i) rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q  <= count_q + n_push - (AW+1)'(pop_i);
        end
    end

endmodule

// File: rtl/thumb_fetch_buffer.sv
// Thumb fetch front end: word fetch, halfword split, 32-bit suffix tagging, redirect.
module thumb_fetch_buffer
    import thumb_fetch_buffer_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    output logic                 imem_req_o,
    output logic [WORD-1:0]      imem_addr_o,
    input  logic [WORD-1:0]      imem_rdata_i,
    input  logic                 imem_rvalid_i,
    input  logic                 branch_valid_i,
    input  logic [WORD-1:0]      branch_target_i,
    input  logic                 instr_ready_i,
    output logic                 instr_valid_o,
    output logic [HALF_WORD-1:0] instr_o,
    output logic [WORD-1:0]      instr_pc_o,
    output logic                 instr_suffix_o
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_e        state_q;
    logic [WORD-1:0]     fetch_addr_q, fetch_addr_d;
    logic [WORD-1:0]     pc_q, pc_d;
    logic                suffix_q, suffix_d;
    logic                epoch_q;
    logic                req_epoch_q;
    logic                drop_low_q;

    logic [CW-1:0]        fifo_cnt;
    logic [HALF_WORD-1:0] fifo_head;
    fifo_push_t           push;
    logic [CW:0]          n_push;
    logic [CW:0]          occ_next;
    logic                 flush, pop, rsp_ok, req;
    logic                 unused_target_b0;

    assign unused_target_b0 = branch_target_i[0];

    assign flush         = branch_valid_i;
    assign instr_valid_o = (fifo_cnt != '0);
    assign pop           = instr_valid_o && instr_ready_i && !flush;
    // A response is only used if it belongs to the current redirect epoch.
    assign rsp_ok        = imem_rvalid_i && (state_q == ST_WAIT) &&
                           (req_epoch_q == epoch_q) && !flush;

    // Split the returned word into halfwords, skipping the low half after an odd-halfword redirect.
    always_comb begin
        push = '0;
        if (rsp_ok) begin
            if (drop_low_q) begin
                push.push1 = 1'b1;
                push.hw0   = imem_rdata_i[31:16];
            end else begin
                push.push2 = 1'b1;
                push.hw0   = imem_rdata_i[15:0];
                push.hw1   = imem_rdata_i[31:16];
            end
        end
    end

    // Occupancy after this edge includes the response landing now, so the next
    // response always has room for two halfwords even if decode stalls.
    assign n_push   = push.push2 ? (CW+1)'(2) : (push.push1 ? (CW+1)'(1) : '0);
    assign occ_next = {1'b0, fifo_cnt} - (CW+1)'(pop) + n_push;
    assign req      = rst_n_i && !flush && (occ_next <= (CW+1)'(DEPTH - 2)) &&
                      ((state_q == ST_IDLE) || imem_rvalid_i);

    assign imem_req_o     = req;
    assign imem_addr_o    = fetch_addr_q;
    assign instr_o        = fifo_head;
    assign instr_pc_o     = pc_q;
    assign instr_suffix_o = suffix_q;

    // Next head PC, suffix tag and fetch address for the non-redirect case.
    always_comb begin
        pc_d         = pc_q;
        suffix_d     = suffix_q;
        fetch_addr_d = fetch_addr_q;
        if (pop) begin
            pc_d     = pc_q + 32'd2;
            suffix_d = suffix_q ? 1'b0 : is_t32_prefix(fifo_head);
        end
        if (req) fetch_addr_d = fetch_addr_q + 32'd4;
    end

    // Fetch FSM with epoch, PC and suffix registers; a redirect overrides everything.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= ST_IDLE;
            fetch_addr_q <= {RESET_PC[31:2], 2'b00};
            pc_q         <= {RESET_PC[31:1], 1'b0};
            suffix_q     <= 1'b0;
            epoch_q      <= 1'b0;
            req_epoch_q  <= 1'b0;
            // An odd-halfword reset PC skips the low half of the first word.
            drop_low_q   <= RESET_PC[1];
        end else if (flush) begin
            state_q      <= ST_IDLE;
            fetch_addr_q <= {branch_target_i[31:2], 2'b00};
            pc_q         <= {branch_target_i[31:1], 1'b0};
            suffix_q     <= 1'b0;
            epoch_q      <= ~epoch_q;
            drop_low_q   <= branch_target_i[1];
        end else begin
            fetch_addr_q <= fetch_addr_d;
            pc_q         <= pc_d;
            suffix_q     <= suffix_d;
            if (rsp_ok) drop_low_q <= 1'b0;
            if (req) begin
                state_q     <= ST_WAIT;
                req_epoch_q <= epoch_q;
            end else if ((state_q == ST_WAIT) && imem_rvalid_i) begin
                state_q     <= ST_IDLE;
            end
        end
    end

    halfword_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .flush_i  (flush),
        .push1_i  (push.push1),
        .push2_i  (push.push2),
        .wdata0_i (push.hw0),
        .wdata1_i (push.hw1),
        .pop_i    (pop),
        .count_o  (fifo_cnt),
        .head_o   (fifo_head)
    );

endmodule

// File: tb/tb_thumb_fetch_buffer.sv
// Directed bench for thumb_fetch_buffer with a one-cycle-latency memory model.
module tb_thumb_fetch_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] rdata_q = '0;
    logic        rvalid_q = 1'b0;
    logic        branch_valid;
    logic [31:0] branch_target;
    logic        instr_ready;
    logic        instr_valid;
    logic [15:0] instr;
    logic [31:0] instr_pc;
    logic        instr_suffix;

    int n_run  = 0;
    int n_fail = 0;
    int w;

    thumb_fetch_buffer #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk_i           (clk),
        .rst_n_i         (rst_n),
        .imem_req_o      (imem_req),
        .imem_addr_o     (imem_addr),
        .imem_rdata_i    (rdata_q),
        .imem_rvalid_i   (rvalid_q),
        .branch_valid_i  (branch_valid),
        .branch_target_i (branch_target),
        .instr_ready_i   (instr_ready),
        .instr_valid_o   (instr_valid),
        .instr_o         (instr),
        .instr_pc_o      (instr_pc),
        .instr_suffix_o  (instr_suffix)
    );

    always #5 clk = ~clk;

    // Generic halfword content: 0x1000 | pc[11:0], never a 32-bit prefix.
    function automatic logic [15:0] gen_hw(input logic [31:0] p);
        return 16'h1000 | {4'h0, p[11:0]};
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a[31:2])
            30'd0:   return 32'h2001_4601;
            30'd1:   return 32'hF800_F000;  // BL pair inside one word
            30'd2:   return 32'hF000_BF00;  // prefix at 0xA ...
            30'd3:   return 32'h4770_F800;  // ... suffix at 0xC
            default: return {gen_hw(a + 32'd2), gen_hw(a)};
        endcase
    endfunction

    // Instruction memory: data one cycle after each request.
    always @(posedge clk) begin
        rvalid_q <= imem_req;
        rdata_q  <= mem_word(imem_addr);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Wait (bounded) for a valid halfword at a negedge, check it, let it pop.
    task automatic expect_hw(input string tag, input logic [15:0] e_ins,
                             input logic [31:0] e_pc, input logic e_sfx, output int waited);
        waited = 0;
        while (!instr_valid && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk({tag, "_vld"}, 32'(instr_valid), 32'd1);
        chk({tag, "_ins"}, 32'(instr), 32'(e_ins));
        chk({tag, "_pc"},  instr_pc, e_pc);
        chk({tag, "_sfx"}, 32'(instr_suffix), 32'(e_sfx));
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] exp_ins [8];
        logic [31:0] exp_pc  [8];
        logic        exp_sfx [8];
        exp_ins = '{16'h4601, 16'h2001, 16'hF000, 16'hF800, 16'hBF00, 16'hF000, 16'hF800, 16'h4770};
        exp_pc  = '{32'h0, 32'h2, 32'h4, 32'h6, 32'h8, 32'hA, 32'hC, 32'hE};
        exp_sfx = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

        rst_n = 1'b0; branch_valid = 1'b0; branch_target = '0; instr_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_vld",  32'(instr_valid), 32'd0);
        chk("rst_req",  32'(imem_req), 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_pc",   instr_pc, 32'h0);
        chk("rst_sfx",  32'(instr_suffix), 32'd0);

        // Stream from reset: plain, in-word BL pair, word-straddling pair.
        rst_n = 1'b1;
        #1;
        chk("p1_req0",  32'(imem_req), 32'd1);
        chk("p1_addr0", imem_addr, 32'h0);
        expect_hw("p1_0", exp_ins[0], exp_pc[0], exp_sfx[0], w);
        chk("p1_lat", 32'(w), 32'd2);
        for (int k = 1; k < 8; k++) expect_hw($sformatf("p1_%0d", k), exp_ins[k], exp_pc[k], exp_sfx[k], w);

        // Decode stall: buffer fills, no request, outputs hold.
        instr_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i >= 6) begin
                chk("p2_vld", 32'(instr_valid), 32'd1);
                chk("p2_req", 32'(imem_req), 32'd0);
                chk("p2_ins", 32'(instr), 32'h1010);
                chk("p2_pc",  instr_pc, 32'h10);
            end
        end
        instr_ready = 1'b1;
        for (int k = 0; k < 8; k++)
            expect_hw($sformatf("p2r_%0d", k), gen_hw(32'h10 + 32'(2*k)), 32'h10 + 32'(2*k), 1'b0, w);

        // Redirect while a response is in flight.
        w = 0;
        while (!rvalid_q && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("p3_inflight", 32'(rvalid_q), 32'd1);
        branch_valid = 1'b1; branch_target = 32'h0000_0102;
        @(negedge clk);
        branch_valid = 1'b0;
        #1;
        chk("p3_req",  32'(imem_req), 32'd1);
        chk("p3_addr", imem_addr, 32'h100);
        expect_hw("p3_0", 16'h1102, 32'h102, 1'b0, w);
        expect_hw("p3_1", 16'h1104, 32'h104, 1'b0, w);

        // Redirect (bit 0 set, ignored) then redirect again while a prefix is being popped.
        branch_valid = 1'b1; branch_target = 32'h0000_0009;
        @(negedge clk);
        branch_valid = 1'b0;
        expect_hw("p4_0", 16'hBF00, 32'h8, 1'b0, w);
        w = 0;
        while (!instr_valid && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("p4_pre_ins", 32'(instr), 32'hF000);
        chk("p4_pre_pc",  instr_pc, 32'hA);
        branch_valid = 1'b1; branch_target = 32'h0000_0102;
        @(negedge clk);
        branch_valid = 1'b0;
        chk("p4_sfx_clr", 32'(instr_suffix), 32'd0);
        expect_hw("p4_1", 16'h1102, 32'h102, 1'b0, w);

        // Address wrap at the top of memory.
        branch_valid = 1'b1; branch_target = 32'hFFFF_FFFC;
        @(negedge clk);
        branch_valid = 1'b0;
        #1;
        chk("wr_addr", imem_addr, 32'hFFFF_FFFC);
        expect_hw("wr_0", 16'h1FFC, 32'hFFFF_FFFC, 1'b0, w);
        expect_hw("wr_1", 16'h1FFE, 32'hFFFF_FFFE, 1'b0, w);
        expect_hw("wr_2", 16'h4601, 32'h0, 1'b0, w);
        expect_hw("wr_3", 16'h2001, 32'h2, 1'b0, w);

        // Asynchronous reset while a read is outstanding and the buffer holds data.
        w = 0;
        while (!(instr_valid && rvalid_q) && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("p5_busy", 32'(instr_valid && rvalid_q), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("p5_vld", 32'(instr_valid), 32'd0);
        chk("p5_req", 32'(imem_req), 32'd0);
        @(negedge clk);
        chk("p5_addr", imem_addr, 32'h0);
        chk("p5_pc",   instr_pc, 32'h0);
        chk("p5_vld2", 32'(instr_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        expect_hw("p5_0", 16'h4601, 32'h0, 1'b0, w);
        chk("p5_lat", 32'(w), 32'd2);
        expect_hw("p5_1", 16'h2001, 32'h2, 1'b0, w);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
